id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline stage register with valid/ready flow control, optional skid buffer, synchronous flush and a stall-cycle counter. It sits between the decode and execute stages of the RISC-V pipeline and replaces the free-running ID/EX latch. Hazard logic can now stall the stage through `out_ready` and squash it through `flush`; squashed slots leave with their control bits forced to zero (bubbles).

## Interface
- `DATA_W`, default 32: width of `data_1`, `data_2` and `imm`.
- `RD_W`, default 5: destination register index width.
- `CTRL_W`, default 4: control bundle width {pcsrc, alusrc, memtoreg, we}, with bit 0 = `we`.
- `SKID`, default 1: 1 selects a 2-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: decode presents a valid instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_data_1`, `in_data_2`, `in_imm` in DATA_W: operands and immediate.
- `in_rd` in RD_W: destination register.
- `in_ctrl` in CTRL_W: control bundle.
- `out_valid` out 1: execute-side entry valid.
- `out_ready` in 1: execute accepts the entry.
- `out_data_1`, `out_data_2`, `out_imm` out DATA_W; `out_rd` out RD_W; `out_ctrl` out CTRL_W.
- `stall_cnt` out CNT_W: saturating count of stalled cycles.

## Operation
- Accept occurs when `in_valid && in_ready`. Issue occurs when `out_valid && out_ready`.
- Storage is a main entry M (drives the outputs) and, when SKID=1, a skid entry S. Each has a valid bit.
- SKID=1 state machine:
  - EMPTY (M invalid): accept → ONE.
  - ONE (M valid, S invalid):
    - accept and issue → ONE, M loads the input.
    - accept without issue → FULL, S loads the input.
    - issue only → EMPTY.
  - FULL (both valid): issue → ONE, M loads from S. No accept is possible in FULL.
  - `in_ready` = !S_valid, driven directly from a flop.
- SKID=0: `in_ready` = `out_ready || !M_valid`. M loads on every accept.
- `flush` has the highest priority. At the next edge it clears M_valid and S_valid, and an input accepted in the same cycle is discarded. Data registers are not cleared by flush.
- `out_ctrl` = M_valid ? M_ctrl : 0. An invalid slot therefore never asserts `we`, `memtoreg` or `pcsrc`.
- Data fields of an invalid M hold their last value. Consumers ignore them.
- `stall_cnt` increments on each cycle with `out_valid && !out_ready`. It saturates at 2^CNT_W−1 and is cleared only by reset.
- Ordering is strict FIFO: S is never issued before M.

## Timing
- Reset (asynchronous on `reset_n`=0) drives:
  - all valid bits = 0
  - `out_data_1`, `out_data_2`, `out_imm`, `out_rd`, `out_ctrl` = 0
  - `stall_cnt` = 0
  - `in_ready` = 1, for both SKID values
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an accept at edge N gives `out_valid`=1 with that entry's fields after edge N, visible in cycle N+1.
- Throughput: 1 entry per cycle while `out_ready`=1, in both modes.
- SKID=1 backpressure: when `out_ready` falls, one more entry is absorbed into S, then `in_ready` drops on the following cycle. No entry is lost or duplicated.
- `flush` together with `in_valid`: after the edge the stage is EMPTY, `out_valid`=0 and `in_ready`=1.
- `flush` while FULL: both entries are dropped, and `stall_cnt` does not increment in the cycle after the flush.
- Saturation: with CNT_W=4, `stall_cnt` holds at 15 under continued stalls.

## Test plan
- Reset, then stream 4 entries (rd=1..4, data_1=0x10..0x13, ctrl=0xF) with `out_ready`=1. Expect the outputs to appear 1 cycle after each accept, in order, with `in_ready` held at 1.
- SKID=1: drop `out_ready` while streaming rd=1,2,3. Expect rd=1 held on the outputs, rd=2 absorbed into S, `in_ready`=0 from the next cycle, and `stall_cnt` counting. Raise `out_ready`; expect rd=1,2,3 to issue in order with no loss or duplication.
- Pulse `flush` while FULL with `in_valid`=1 (rd=7). Expect `out_valid`=0, `out_ctrl`=0, `in_ready`=1 next cycle, and rd=7 never issued.
- SKID=0: hold `out_ready`=0 with M valid. Expect `in_ready`=0 combinationally. Set `out_ready`=1 in the same cycle as `in_valid`; expect the accept and the issue in one cycle.
- CNT_W=4: stall for 20 cycles. Expect `stall_cnt` to reach 15 and hold. Then assert reset; expect `stall_cnt`=0.
- Assert `reset_n`=0 asynchronously between edges while FULL. Expect `out_valid`=0 and `out_ctrl`=0 immediately, and `in_ready`=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with valid/ready flow control, optional skid entry, flush and stall counter.
// Revision: 1.0
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [DATA_W-1:0] out_imm,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = 3*DATA_W + RD_W + CTRL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bit 0 = main entry valid, bit 1 = skid entry valid; in_ready comes straight off bit 1.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  logic [ENT_W-1:0] in_entry;
  logic [ENT_W-1:0] m_entry;
  logic             m_valid;
  logic             accept;
  logic             issue;

  assign in_entry  = {in_data_1, in_data_2, in_imm, in_rd, in_ctrl};
  assign accept    = in_valid && in_ready;
  assign issue     = m_valid && out_ready;
  assign out_valid = m_valid;
  assign {out_data_1, out_data_2, out_imm, out_rd} = m_entry[ENT_W-1:CTRL_W];
  assign out_ctrl  = m_valid ? m_entry[CTRL_W-1:0] : '0;

  generate
    if (SKID != 0) begin : g_skid
      state_t           state_q;
      state_t           state_d;
      logic [ENT_W-1:0] s_entry;
      logic             load_m_in;
      logic             load_s_in;
      logic             load_m_s;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
      end

      always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_s_in = 1'b0;
        load_m_s  = 1'b0;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: if (accept) begin
              state_d   = ONE;
              load_m_in = 1'b1;
            end
            ONE: begin
              if (accept && issue) begin
                load_m_in = 1'b1;
              end else if (accept) begin
                state_d   = FULL;
                load_s_in = 1'b1;
              end else if (issue) begin
                state_d = EMPTY;
              end
            end
            FULL: if (issue) begin
              state_d  = ONE;
              load_m_s = 1'b1;
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          m_entry <= '0;
          s_entry <= '0;
        end else begin
          if (load_m_in)     m_entry <= in_entry;
          else if (load_m_s) m_entry <= s_entry;
          if (load_s_in)     s_entry <= in_entry;
        end
      end

      assign m_valid  = state_q[0];
      assign in_ready = ~state_q[1];
    end else begin : g_single
      logic m_valid_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          m_valid_q <= 1'b0;
          m_entry   <= '0;
        end else if (flush) begin
          m_valid_q <= 1'b0;
        end else if (accept) begin
          m_valid_q <= 1'b1;
          m_entry   <= in_entry;
        end else if (issue) begin
          m_valid_q <= 1'b0;
        end
      end

      assign m_valid  = m_valid_q;
      assign in_ready = out_ready || !m_valid_q;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (m_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: skid instance (CNT_W=4) and single-register instance.
`default_nettype none

module tb_id_ex_stage;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  // Instance a: SKID=1, CNT_W=4
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_d1, a_in_d2, a_in_imm, a_out_d1, a_out_d2, a_out_imm;
  logic [4:0]  a_in_rd, a_out_rd;
  logic [3:0]  a_in_ctrl, a_out_ctrl;
  logic [3:0]  a_cnt;

  // Instance b: SKID=0, CNT_W=16
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_d1, b_in_d2, b_in_imm, b_out_d1, b_out_d2, b_out_imm;
  logic [4:0]  b_in_rd, b_out_rd;
  logic [3:0]  b_in_ctrl, b_out_ctrl;
  logic [15:0] b_cnt;

  id_ex_stage #(.DATA_W(32), .RD_W(5), .CTRL_W(4), .SKID(1), .CNT_W(4)) u_a (
    .clock(clock), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data_1(a_in_d1), .in_data_2(a_in_d2), .in_imm(a_in_imm),
    .in_rd(a_in_rd), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data_1(a_out_d1), .out_data_2(a_out_d2), .out_imm(a_out_imm),
    .out_rd(a_out_rd), .out_ctrl(a_out_ctrl), .stall_cnt(a_cnt)
  );

  id_ex_stage #(.DATA_W(32), .RD_W(5), .CTRL_W(4), .SKID(0), .CNT_W(16)) u_b (
    .clock(clock), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data_1(b_in_d1), .in_data_2(b_in_d2), .in_imm(b_in_imm),
    .in_rd(b_in_rd), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data_1(b_out_d1), .out_data_2(b_out_d2), .out_imm(b_out_imm),
    .out_rd(b_out_rd), .out_ctrl(b_out_ctrl), .stall_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [4:0] rd, input logic [31:0] d1, input logic [3:0] ctrl);
    a_in_valid = v;
    a_in_rd    = rd;
    a_in_d1    = d1;
    a_in_d2    = ~d1;
    a_in_imm   = d1 + 32'h100;
    a_in_ctrl  = ctrl;
  endtask

  task automatic b_drive(input logic v, input logic [4:0] rd, input logic [31:0] d1, input logic [3:0] ctrl);
    b_in_valid = v;
    b_in_rd    = rd;
    b_in_d1    = d1;
    b_in_d2    = ~d1;
    b_in_imm   = d1 + 32'h100;
    b_in_ctrl  = ctrl;
  endtask

  initial begin
    reset_n = 1'b0;
    a_flush = 1'b0; a_out_ready = 1'b0; a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    b_flush = 1'b0; b_out_ready = 1'b0; b_drive(1'b0, 5'd0, 32'h0, 4'h0);
    #12;
    check("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("a_rst_in_ready",  32'(a_in_ready),  32'd1);
    check("a_rst_out_rd",    32'(a_out_rd),    32'd0);
    check("a_rst_out_d1",    a_out_d1,         32'd0);
    check("a_rst_out_imm",   a_out_imm,        32'd0);
    check("a_rst_out_ctrl",  32'(a_out_ctrl),  32'd0);
    check("a_rst_cnt",       32'(a_cnt),       32'd0);
    check("b_rst_in_ready",  32'(b_in_ready),  32'd1);
    check("b_rst_out_valid", 32'(b_out_valid), 32'd0);
    reset_n = 1'b1;

    // ---- SKID=1: streaming at full rate
    a_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_drive(1'b1, 5'(i), 32'h10 + 32'(i - 1), 4'hF);
      tick();
      check("a_stream_valid", 32'(a_out_valid), 32'd1);
      check("a_stream_rd",    32'(a_out_rd),    32'(i));
      check("a_stream_d1",    a_out_d1,         32'h10 + 32'(i - 1));
      check("a_stream_d2",    a_out_d2,         ~(32'h10 + 32'(i - 1)));
      check("a_stream_ctrl",  32'(a_out_ctrl),  32'hF);
      check("a_stream_ready", 32'(a_in_ready),  32'd1);
    end
    a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    tick();
    check("a_drain_valid", 32'(a_out_valid), 32'd0);
    check("a_drain_ctrl",  32'(a_out_ctrl),  32'd0);

    // ---- SKID=1: backpressure absorbs one entry into the skid slot
    a_drive(1'b1, 5'd1, 32'h21, 4'h3);
    tick();
    check("a_bp_rd1", 32'(a_out_rd), 32'd1);
    a_out_ready = 1'b0;
    a_drive(1'b1, 5'd2, 32'h22, 4'h3);
    tick();
    check("a_bp_hold_rd1",  32'(a_out_rd),   32'd1);
    check("a_bp_ready_low", 32'(a_in_ready), 32'd0);
    check("a_bp_cnt1",      32'(a_cnt),      32'd1);
    a_drive(1'b1, 5'd3, 32'h23, 4'h3);
    tick();
    check("a_bp_still_rd1", 32'(a_out_rd),   32'd1);
    check("a_bp_ready_low2",32'(a_in_ready), 32'd0);
    check("a_bp_cnt2",      32'(a_cnt),      32'd2);
    a_out_ready = 1'b1;
    tick();
    check("a_bp_rd2",       32'(a_out_rd),   32'd2);
    check("a_bp_rd2_d1",    a_out_d1,        32'h22);
    check("a_bp_ready_up",  32'(a_in_ready), 32'd1);
    tick();
    check("a_bp_rd3",       32'(a_out_rd),   32'd3);
    check("a_bp_rd3_valid", 32'(a_out_valid),32'd1);
    a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    tick();
    check("a_bp_empty",     32'(a_out_valid),32'd0);
    check("a_bp_cnt_keep",  32'(a_cnt),      32'd2);

    // ---- SKID=1: flush while FULL with an input offered
    a_out_ready = 1'b0;
    a_drive(1'b1, 5'd5, 32'h25, 4'hF);
    tick();
    a_drive(1'b1, 5'd6, 32'h26, 4'hF);
    tick();
    check("a_full_ready", 32'(a_in_ready), 32'd0);
    check("a_full_cnt",   32'(a_cnt),      32'd3);
    a_flush = 1'b1;
    a_drive(1'b1, 5'd7, 32'h27, 4'hF);
    tick();
    a_flush = 1'b0;
    a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    check("a_flush_valid", 32'(a_out_valid), 32'd0);
    check("a_flush_ctrl",  32'(a_out_ctrl),  32'd0);
    check("a_flush_ready", 32'(a_in_ready),  32'd1);
    check("a_flush_cnt",   32'(a_cnt),       32'd4);
    tick();
    check("a_flush_cnt_hold", 32'(a_cnt), 32'd4);
    a_out_ready = 1'b1;
    tick();
    check("a_rd7_not_issued", 32'(a_out_valid), 32'd0);

    // Flush alongside an accept from EMPTY discards the input
    a_flush = 1'b1;
    a_drive(1'b1, 5'd8, 32'h28, 4'hF);
    tick();
    a_flush = 1'b0;
    a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    check("a_flush_acc_valid", 32'(a_out_valid), 32'd0);
    check("a_flush_acc_ready", 32'(a_in_ready),  32'd1);

    // ---- SKID=1: counter saturation at 15
    a_drive(1'b1, 5'd9, 32'h29, 4'h5);
    tick();
    a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    a_out_ready = 1'b0;
    repeat (5) tick();
    check("a_cnt_9", 32'(a_cnt), 32'd9);
    repeat (15) tick();
    check("a_cnt_sat",  32'(a_cnt), 32'd15);
    tick();
    check("a_cnt_hold", 32'(a_cnt), 32'd15);

    // ---- SKID=1: asynchronous reset while FULL
    a_drive(1'b1, 5'd10, 32'h2A, 4'hF);
    tick();
    a_drive(1'b0, 5'd0, 32'h0, 4'h0);
    check("a_pre_rst_ctrl",  32'(a_out_ctrl), 32'h5);
    check("a_pre_rst_ready", 32'(a_in_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("a_arst_valid", 32'(a_out_valid), 32'd0);
    check("a_arst_ctrl",  32'(a_out_ctrl),  32'd0);
    check("a_arst_ready", 32'(a_in_ready),  32'd1);
    check("a_arst_cnt",   32'(a_cnt),       32'd0);
    check("a_arst_rd",    32'(a_out_rd),    32'd0);
    #1;
    reset_n = 1'b1;

    // ---- SKID=0: streaming, combinational ready, same-cycle accept+issue
    b_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_drive(1'b1, 5'(i), 32'h10 + 32'(i - 1), 4'hF);
      tick();
      check("b_stream_rd",    32'(b_out_rd),   32'(i));
      check("b_stream_d1",    b_out_d1,        32'h10 + 32'(i - 1));
      check("b_stream_imm",   b_out_imm,       32'h110 + 32'(i - 1));
      check("b_stream_ready", 32'(b_in_ready), 32'd1);
    end
    b_out_ready = 1'b0;
    b_drive(1'b1, 5'd5, 32'h35, 4'h9);
    #1;
    check("b_comb_ready_low", 32'(b_in_ready), 32'd0);
    tick();
    check("b_stall_rd",  32'(b_out_rd), 32'd4);
    check("b_stall_cnt", 32'(b_cnt),    32'd1);
    b_out_ready = 1'b1;
    #1;
    check("b_comb_ready_high", 32'(b_in_ready), 32'd1);
    tick();
    check("b_passthru_rd",    32'(b_out_rd),    32'd5);
    check("b_passthru_ctrl",  32'(b_out_ctrl),  32'h9);
    check("b_passthru_valid", 32'(b_out_valid), 32'd1);
    b_flush = 1'b1;
    b_drive(1'b1, 5'd6, 32'h36, 4'hF);
    tick();
    b_flush = 1'b0;
    b_drive(1'b0, 5'd0, 32'h0, 4'h0);
    b_out_ready = 1'b0;
    #1;
    check("b_flush_valid", 32'(b_out_valid), 32'd0);
    check("b_flush_ctrl",  32'(b_out_ctrl),  32'd0);
    check("b_flush_ready", 32'(b_in_ready),  32'd1);
    check("b_flush_cnt",   32'(b_cnt),       32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
